// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 with optional parity.
// 3-sample majority vote per bit, one-cycle result strobes.
module uart_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] PRESCALE,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       DATA_VALID,
  output logic       PAR_ERR,
  output logic       STP_ERR
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [5:0] edge_cnt;
  logic [5:0] presc_q;
  logic [5:0] half;
  logic [2:0] bit_cnt;
  logic [2:0] samp;
  logic [7:0] shift_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic       par_fail;

  logic       maj;
  logic       bit_end;
  logic       start_det;
  logic       frame_done;
  logic       stp_fail;
  logic       dv_d;
  logic       pe_d;
  logic       se_d;

  assign half    = {1'b0, presc_q[5:1]};
  assign bit_end = (state_q != IDLE) &&
                   (edge_cnt == presc_q - 6'd1);

  assign maj = (samp[0] & samp[1]) |
               (samp[0] & samp[2]) |
               (samp[1] & samp[2]);

  // A low line at the stop decision starts the next
  // frame at once, so zero-gap frames keep alignment.
  assign start_det = !RX_IN &&
                     ((state_q == IDLE) ||
                      (state_q == STOP && bit_end));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!RX_IN) state_d = START;
      end
      START: begin
        if (bit_end) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == 3'd7)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = RX_IN ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_fail  <= 1'b0;
      samp      <= 3'b111;
      shift_q   <= '0;
    end else begin
      if (start_det) begin
        presc_q   <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_fail  <= 1'b0;
        bit_cnt   <= '0;
      end

      if (start_det || state_q == IDLE || bit_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end

      if (state_q != IDLE) begin
        unique case (1'b1)
          edge_cnt == half - 6'd1: samp[0] <= RX_IN;
          edge_cnt == half:        samp[1] <= RX_IN;
          edge_cnt == half + 6'd1: samp[2] <= RX_IN;
          default: ;
        endcase
      end

      if (state_q == DATA && bit_end) begin
        shift_q <= {maj, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state_q == PARITY && bit_end) begin
        par_fail <= maj != (^shift_q ^ par_typ_q);
      end
    end
  end

  always_comb begin
    frame_done = (state_q == STOP) && bit_end;
    stp_fail   = frame_done && !maj;
    dv_d       = frame_done && maj && !par_fail;
    pe_d       = frame_done && par_fail;
    se_d       = stp_fail;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= dv_d;
      PAR_ERR    <= pe_d;
      STP_ERR    <= se_d;
      if (dv_d) P_DATA <= shift_q;
    end
  end

endmodule
